// File: rtl/core_pkg.sv
// Shared core definitions: default bank geometry and the register-index / data-word types.
package core_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREGS = 32;

    typedef logic [$clog2(DEF_NREGS)-1:0] reg_idx_t;
    typedef logic [DEF_WIDTH-1:0]         word_t;

endpackage

// File: rtl/regfile_sb_counter.sv
// sb_counter: one pending-write counter; increments on inc, decrements on dec, holds when both.
// Saturates at all-ones and never wraps below zero.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             inc_ok
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             do_inc;
    logic             do_dec;

    always_comb begin
        do_inc   = inc & (cnt_reg != CNT_MAX);
        do_dec   = dec & (cnt_reg != '0);
        cnt_next = cnt_reg;
        if (do_inc && !do_dec) begin
            cnt_next = cnt_reg + 1'b1;
        end else if (do_dec && !do_inc) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt    = cnt_reg;
    assign inc_ok = (cnt_reg != CNT_MAX);

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register bank with NRD combinational read ports, one WB write port and a
// per-register in-flight-write scoreboard. Define REGFILE_BYPASS_EN for WB-to-read forwarding.
module regfile_sb
    import core_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = 2,
    parameter int CNT_W = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NRD*$clog2(NREGS)-1:0]   ra,
    output logic [NRD*WIDTH-1:0]           rd_data,
    output logic [NRD-1:0]                 rd_busy,
    output logic                           stall,
    input  logic [NRD-1:0]                 ra_en,
    input  logic                           iss_valid,
    input  logic [$clog2(NREGS)-1:0]       iss_rd,
    output logic                           iss_ready,
    input  logic                           we,
    input  logic [$clog2(NREGS)-1:0]       wa,
    input  logic [WIDTH-1:0]               wd,
    output logic [NREGS*WIDTH-1:0]         dbg_regs
);

    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0][WIDTH-1:0] bank_view;
    logic [NREGS-1:0][CNT_W-1:0] cnt_view;
    logic [NREGS-1:0]            inc_ok_vec;
    logic                        iss_acc;

    // r0 has no storage and no counter: it reads as zero and is never busy.
    assign bank_view[0]  = '0;
    assign cnt_view[0]   = '0;
    assign inc_ok_vec[0] = 1'b1;

    assign iss_ready = inc_ok_vec[iss_rd] | (iss_rd == '0);
    assign iss_acc   = iss_valid & iss_ready & (iss_rd != '0);

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [WIDTH-1:0] word_reg;
            logic             wr_hit;
            logic             iss_hit;

            assign wr_hit  = we & (wa == AW'(gi));
            assign iss_hit = iss_acc & (iss_rd == AW'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    word_reg <= '0;
                end else if (wr_hit) begin
                    word_reg <= wd;
                end
            end

            // A write with no pending count is untracked; the counter ignores dec at zero.
            sb_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk    (clk),
                .rst    (rst),
                .inc    (iss_hit),
                .dec    (wr_hit),
                .cnt    (cnt_view[gi]),
                .inc_ok (inc_ok_vec[gi])
            );

            assign bank_view[gi] = word_reg;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic          pend;

            assign addr = ra[gi*AW +: AW];
            assign pend = (cnt_view[addr] != '0) & (addr != '0);
`ifdef REGFILE_BYPASS_EN
            logic hit;
            assign hit = we & (wa == addr) & (addr != '0);
            // Forward WB data and drop busy when this write retires the last pending count.
            assign rd_data[gi*WIDTH +: WIDTH] = hit ? wd : bank_view[addr];
            assign rd_busy[gi] = pend & ~(hit & (cnt_view[addr] == CNT_W'(1)));
`else
            assign rd_data[gi*WIDTH +: WIDTH] = bank_view[addr];
            assign rd_busy[gi] = pend;
`endif
        end
    endgenerate

    assign stall    = |(rd_busy & ra_en);
    assign dbg_regs = bank_view;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; expectations adapt to REGFILE_BYPASS_EN.
module tb_regfile_sb;
    import core_pkg::*;

    localparam int NRD   = 2;
    localparam int CNT_W = 2;
    localparam int AW    = $clog2(DEF_NREGS);

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NRD*AW-1:0]            ra;
    logic [NRD*DEF_WIDTH-1:0]     rd_data;
    logic [NRD-1:0]               rd_busy;
    logic                         stall;
    logic [NRD-1:0]               ra_en;
    logic                         iss_valid;
    reg_idx_t                     iss_rd;
    logic                         iss_ready;
    logic                         we;
    reg_idx_t                     wa;
    word_t                        wd;
    logic [DEF_NREGS*DEF_WIDTH-1:0] dbg_regs;

    int err_cnt = 0;
    int chk_cnt = 0;

    regfile_sb #(
        .WIDTH (DEF_WIDTH),
        .NREGS (DEF_NREGS),
        .NRD   (NRD),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ra        (ra),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .stall     (stall),
        .ra_en     (ra_en),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .dbg_regs  (dbg_regs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic set_ra(input reg_idx_t a0, input reg_idx_t a1);
        ra = {a1, a0};
    endtask

    // Inputs change on the falling edge; combinational outputs are sampled 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic word_t rd0();
        return rd_data[DEF_WIDTH-1:0];
    endfunction

    function automatic word_t bank_at(input int r);
        return dbg_regs[r*DEF_WIDTH +: DEF_WIDTH];
    endfunction

    initial begin
        rst = 1'b0; ra = '0; ra_en = '0; iss_valid = 1'b0; iss_rd = 5'd5;
        we = 1'b0; wa = '0; wd = '0;

        // Reset
        repeat (2) @(posedge clk);
        cyc(); #1;
        check("rst_dbg_zero", 64'(|dbg_regs), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_iss_ready", 64'(iss_ready), 64'd1);
        rst = 1'b1;
        set_ra(5'd5, 5'd7);
        #1;
        check("rst_rd0", 64'(rd_data[31:0]), 64'd0);
        check("rst_rd1", 64'(rd_data[63:32]), 64'd0);
        check("rst_busy", 64'(rd_busy), 64'd0);

        // Plain write / read
        cyc(); we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF;
        cyc(); we = 1'b0; set_ra(5'd3, 5'd0); #1;
        check("wr_rd_r3", 64'(rd0()), 64'h0000_0000_DEAD_BEEF);
        check("wr_dbg_r3", 64'(bank_at(3)), 64'h0000_0000_DEAD_BEEF);
        cyc(); we = 1'b1; wa = 5'd0; wd = 32'h1234;
        cyc(); we = 1'b0; set_ra(5'd0, 5'd0); #1;
        check("wr_r0_zero", 64'(rd0()), 64'd0);
        check("wr_r0_busy", 64'(rd_busy[0]), 64'd0);

        // Scoreboard stall
        cyc(); iss_valid = 1'b1; iss_rd = 5'd4;
        cyc(); iss_valid = 1'b0; set_ra(5'd4, 5'd4); ra_en = 2'b01; #1;
        check("sb_stall", 64'(stall), 64'd1);
        check("sb_busy", 64'(rd_busy), 64'd3);
        ra_en = 2'b00; #1;
        check("sb_stall_masked", 64'(stall), 64'd0);
        ra_en = 2'b10; #1;
        check("sb_stall_port1", 64'(stall), 64'd1);
        cyc(); ra_en = 2'b01; we = 1'b1; wa = 5'd4; wd = 32'h55; #1;
`ifdef REGFILE_BYPASS_EN
        check("sb_wb_stall", 64'(stall), 64'd0);
        check("sb_wb_data", 64'(rd0()), 64'h55);
`else
        check("sb_wb_stall", 64'(stall), 64'd1);
        check("sb_wb_data", 64'(rd0()), 64'd0);
`endif
        cyc(); we = 1'b0; #1;
        check("sb_after_stall", 64'(stall), 64'd0);
        check("sb_after_data", 64'(rd0()), 64'h55);
        ra_en = 2'b00;

        // Saturation at 2^CNT_W-1 = 3
        cyc(); iss_valid = 1'b1; iss_rd = 5'd9;
        cyc(); cyc();
        cyc(); iss_valid = 1'b0; #1;
        check("sat_ready_r9", 64'(iss_ready), 64'd0);
        iss_rd = 5'd10; #1;
        check("sat_ready_r10", 64'(iss_ready), 64'd1);
        // Saturated issue is not accepted and is held; the retire alone frees a slot.
        cyc(); iss_valid = 1'b1; iss_rd = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h99; #1;
        check("sat_hold_ready", 64'(iss_ready), 64'd0);
        cyc(); we = 1'b0;
        cyc(); iss_valid = 1'b0; #1;
        check("sat_keeps_3", 64'(iss_ready), 64'd0);
        check("sat_bank_r9", 64'(bank_at(9)), 64'h99);
        // 3 -> 2 by retire, then issue+retire same register leaves 2
        cyc(); we = 1'b1; wa = 5'd9; wd = 32'h98;
        cyc(); iss_valid = 1'b1; iss_rd = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h97;
        cyc(); iss_valid = 1'b0; we = 1'b0; #1;
        check("same_reg_unchanged", 64'(iss_ready), 64'd1);
        cyc(); iss_valid = 1'b1;
        cyc(); iss_valid = 1'b0; #1;
        check("same_reg_was_2", 64'(iss_ready), 64'd0);
        // Issue r11 while retiring r9: both counters move
        cyc(); iss_valid = 1'b1; iss_rd = 5'd11; we = 1'b1; wa = 5'd9; wd = 32'h96;
        cyc(); iss_valid = 1'b0; we = 1'b0; iss_rd = 5'd9; set_ra(5'd11, 5'd9); #1;
        check("diff_reg_r9_dec", 64'(iss_ready), 64'd1);
        check("diff_reg_busy", 64'(rd_busy), 64'd3);

        // Untracked write
        cyc(); we = 1'b1; wa = 5'd6; wd = 32'h66;
        cyc(); we = 1'b0; set_ra(5'd6, 5'd0); iss_rd = 5'd6; #1;
        check("untracked_data", 64'(rd0()), 64'h66);
        check("untracked_busy", 64'(rd_busy[0]), 64'd0);
        check("untracked_no_wrap", 64'(iss_ready), 64'd1);

        // Async reset with two writes in flight on r4
        cyc(); iss_valid = 1'b1; iss_rd = 5'd4;
        cyc(); cyc(); iss_valid = 1'b0; set_ra(5'd4, 5'd0); ra_en = 2'b01; #1;
        check("pre_arst_stall", 64'(stall), 64'd1);
        check("pre_arst_data", 64'(rd0()), 64'h55);
        #2 rst = 1'b0; #1;
        check("arst_stall", 64'(stall), 64'd0);
        check("arst_data", 64'(rd0()), 64'd0);
        check("arst_ready", 64'(iss_ready), 64'd1);
        cyc(); rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
